// File: rtl/wb_arb_pkg.sv
// Shared encodings for the two-master Wishbone arbiter: FSM states, grant codes,
// round-robin pointer values and the memory size codes.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_M0   = 2'd1,
    GNT_M1   = 2'd2
  } gnt_e;

  localparam logic PTR_M0 = 1'b0;
  localparam logic PTR_M1 = 1'b1;

  // Size codes understood by the unified memory.
  localparam logic [2:0] SEL_BYTE  = 3'b000;
  localparam logic [2:0] SEL_HALF  = 3'b001;
  localparam logic [2:0] SEL_WORD  = 3'b010;
  localparam logic [2:0] SEL_BYTEU = 3'b100;
  localparam logic [2:0] SEL_HALFU = 3'b101;

  function automatic logic sel_is_valid(input logic [2:0] sel);
    return sel inside {SEL_BYTE, SEL_HALF, SEL_WORD, SEL_BYTEU, SEL_HALFU};
  endfunction

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational winner selection for wb_arbiter2.
// WB_ARB_RR_EN defined: round-robin, ptr_i names the preferred master on a tie.
// WB_ARB_RR_EN undefined: fixed priority, m1 over m0; ptr_i is ignored.
module wb_arb_pick
  import wb_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic ptr_i,
  output gnt_e win_o
);

`ifdef WB_ARB_RR_EN
  // Tie goes to the pointer's master; a lone requester always wins.
  always_comb begin
    win_o = GNT_NONE;
    if (req0_i && req1_i) begin
      win_o = (ptr_i == PTR_M1) ? GNT_M1 : GNT_M0;
    end else if (req1_i) begin
      win_o = GNT_M1;
    end else if (req0_i) begin
      win_o = GNT_M0;
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ptr_i;

  // Fixed priority: m1 wins whenever it requests.
  always_comb begin
    win_o = GNT_NONE;
    if (req1_i) begin
      win_o = GNT_M1;
    end else if (req0_i) begin
      win_o = GNT_M0;
    end
  end
`endif

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master to one-slave Wishbone (stb/stall/ack) arbiter in front of the unified
// memory. One transaction outstanding; ack and read data go back to its issuer.
// Optional macro WB_ARB_RR_EN selects round-robin instead of fixed m1 > m0 priority.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_m0_stb,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [DW-1:0] i_m0_data,
  input  logic          i_m0_we,
  input  logic [2:0]    i_m0_sel,
  input  logic          i_m1_stb,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m1_data,
  input  logic          i_m1_we,
  input  logic [2:0]    i_m1_sel,
  output logic          o_m0_stall,
  output logic          o_m0_ack,
  output logic [DW-1:0] o_m0_data,
  output logic          o_m1_stall,
  output logic          o_m1_ack,
  output logic [DW-1:0] o_m1_data,
  output logic          o_s_stb,
  output logic [AW-1:0] o_s_addr,
  output logic [DW-1:0] o_s_data,
  output logic          o_s_we,
  output logic [2:0]    o_s_sel,
  input  logic          i_s_stall,
  input  logic          i_s_ack,
  input  logic [DW-1:0] i_s_data,
  output logic          o_busy
);

  state_e state_q, state_d;
  gnt_e   gnt_q, gnt_d;
  gnt_e   win;
  logic   ptr;

  wb_arb_pick u_pick (
    .req0_i (i_m0_stb),
    .req1_i (i_m1_stb),
    .ptr_i  (ptr),
    .win_o  (win)
  );

`ifdef WB_ARB_RR_EN
  logic ptr_q, ptr_d;

  // Pointer moves away from whichever master was just granted.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_IDLE && win != GNT_NONE) begin
      ptr_d = (win == GNT_M0) ? PTR_M1 : PTR_M0;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ptr_q <= PTR_M0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = PTR_M0;
`endif

  // State and grant registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      gnt_q   <= GNT_NONE;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
    end
  end

  // Next-state: grant in IDLE, wait for slave accept, then wait for ack.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    case (state_q)
      S_IDLE: begin
        if (win != GNT_NONE) begin
          gnt_d   = win;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!i_s_stall) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_s_ack) begin
          state_d = S_IDLE;
          gnt_d   = GNT_NONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = GNT_NONE;
      end
    endcase
  end

  // Outputs: slave fields only driven in ISSUE; ack forwarded only in WAIT.
  always_comb begin
    o_s_stb    = 1'b0;
    o_s_addr   = '0;
    o_s_data   = '0;
    o_s_we     = 1'b0;
    o_s_sel    = 3'b000;
    o_m0_stall = 1'b1;
    o_m1_stall = 1'b1;
    o_m0_ack   = 1'b0;
    o_m1_ack   = 1'b0;
    o_m0_data  = '0;
    o_m1_data  = '0;
    o_busy     = (state_q != S_IDLE);
    if (state_q == S_ISSUE) begin
      o_s_stb = 1'b1;
      case (gnt_q)
        GNT_M0: begin
          o_s_addr   = i_m0_addr;
          o_s_data   = i_m0_data;
          o_s_we     = i_m0_we;
          o_s_sel    = i_m0_sel;
          o_m0_stall = i_s_stall;
        end
        GNT_M1: begin
          o_s_addr   = i_m1_addr;
          o_s_data   = i_m1_data;
          o_s_we     = i_m1_we;
          o_s_sel    = i_m1_sel;
          o_m1_stall = i_s_stall;
        end
        default: ;
      endcase
    end else if (state_q == S_WAIT && i_s_ack) begin
      case (gnt_q)
        GNT_M0: begin
          o_m0_ack  = 1'b1;
          o_m0_data = i_s_data;
        end
        GNT_M1: begin
          o_m1_ack  = 1'b1;
          o_m1_data = i_s_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: memory slave model with 2-cycle ack latency,
// a transaction-level arbiter model compared every cycle, and directed literal checks.
module tb_wb_arbiter2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_stb  [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wd   [2];
  logic        m_we   [2];
  logic [2:0]  m_sel  [2];
  logic        d_stall[2];
  logic        d_ack  [2];
  logic [31:0] d_data [2];
  logic        s_stb, s_we, busy;
  logic [31:0] s_addr, s_data;
  logic [2:0]  s_sel;
  logic        s_stall;
  logic        s_ack_q = 1'b0;
  logic [31:0] s_rdata_q = '0;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int cyc0     = 0;

  always #5 clk = ~clk;

  wb_arbiter2 #(.AW(32), .DW(32)) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_m0_stb   (m_stb[0]),
    .i_m0_addr  (m_addr[0]),
    .i_m0_data  (m_wd[0]),
    .i_m0_we    (m_we[0]),
    .i_m0_sel   (m_sel[0]),
    .i_m1_stb   (m_stb[1]),
    .i_m1_addr  (m_addr[1]),
    .i_m1_data  (m_wd[1]),
    .i_m1_we    (m_we[1]),
    .i_m1_sel   (m_sel[1]),
    .o_m0_stall (d_stall[0]),
    .o_m0_ack   (d_ack[0]),
    .o_m0_data  (d_data[0]),
    .o_m1_stall (d_stall[1]),
    .o_m1_ack   (d_ack[1]),
    .o_m1_data  (d_data[1]),
    .o_s_stb    (s_stb),
    .o_s_addr   (s_addr),
    .o_s_data   (s_data),
    .o_s_we     (s_we),
    .o_s_sel    (s_sel),
    .i_s_stall  (s_stall),
    .i_s_ack    (s_ack_q),
    .i_s_data   (s_rdata_q),
    .o_busy     (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory slave model (not reset, so late acks survive) ----------
  logic [7:0]  mem [0:255];
  logic        st1_v = 1'b0;
  logic [31:0] st1_d = '0;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [2:0]  acc_sel;

  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [2:0] sel);
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[a[7:0]];
    b1 = mem[a[7:0] + 8'd1];
    b2 = mem[a[7:0] + 8'd2];
    b3 = mem[a[7:0] + 8'd3];
    case (sel)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b100:  return {24'h0, b0};
      3'b101:  return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  always @(posedge clk) begin
    st1_v     <= s_stb && !s_stall;
    st1_d     <= mem_rd(s_addr, s_sel);
    s_ack_q   <= st1_v;
    s_rdata_q <= st1_d;
    if (s_stb && !s_stall) begin
      acc_we   <= s_we;
      acc_addr <= s_addr;
      acc_sel  <= s_sel;
      if (s_we) begin
        mem[s_addr[7:0]] <= s_data[7:0];
        if (s_sel[1:0] != 2'b00) mem[s_addr[7:0] + 8'd1] <= s_data[15:8];
        if (s_sel == 3'b010) begin
          mem[s_addr[7:0] + 8'd2] <= s_data[23:16];
          mem[s_addr[7:0] + 8'd3] <= s_data[31:24];
        end
      end
    end
  end

  // ---------------- arbiter model: one owner, accepted or not ----------------------
  int   mo_owner = -1;
  logic mo_acc   = 1'b0;
  logic mo_ptr   = 1'b0;
  bit   model_ok;

  function automatic int pick(input logic r0, input logic r1, input logic p);
`ifdef WB_ARB_RR_EN
    if (r0 && r1) return p ? 1 : 0;
`endif
    if (r1) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    int w;
    if (!rst_n) begin
      mo_owner <= -1;
      mo_acc   <= 1'b0;
      mo_ptr   <= 1'b0;
      model_ok <= 1'b1;
    end else if (mo_owner < 0) begin
      if (m_stb[0] || m_stb[1]) begin
        w = pick(m_stb[0], m_stb[1], mo_ptr);
        mo_owner <= w;
        mo_acc   <= 1'b0;
        mo_ptr   <= (w == 0);
      end
    end else if (!mo_acc) begin
      if (!s_stall) mo_acc <= 1'b1;
    end else if (s_ack_q) begin
      mo_owner <= -1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic e_stb, e_stall, e_ack;
    logic [31:0] e_data;
    if (model_ok) begin
      e_stb = (mo_owner >= 0) && !mo_acc;
      chk("s_stb", s_stb, e_stb);
      chk("busy", busy, mo_owner >= 0);
      for (int m = 0; m < 2; m++) begin
        e_stall = (e_stb && mo_owner == m) ? s_stall : 1'b1;
        e_ack   = (mo_owner == m) && mo_acc && s_ack_q;
        e_data  = e_ack ? s_rdata_q : 32'h0;
        chk($sformatf("m%0d_stall", m), d_stall[m], e_stall);
        chk($sformatf("m%0d_ack", m), d_ack[m], e_ack);
        chk($sformatf("m%0d_data", m), d_data[m], e_data);
      end
      if (e_stb) begin
        chk("s_addr", s_addr, m_addr[mo_owner]);
        chk("s_data", s_data, m_wd[mo_owner]);
        chk("s_we", s_we, m_we[mo_owner]);
        chk("s_sel", s_sel, m_sel[mo_owner]);
      end
    end
  end

  // ---------------- ack log ----------------
  int          ack_m[$];
  int          ack_c[$];
  logic [31:0] ack_d[$];

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (d_ack[m] === 1'b1) begin
        ack_m.push_back(m);
        ack_c.push_back(cyc);
        ack_d.push_back(d_data[m]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_phase();
    ack_m.delete();
    ack_c.delete();
    ack_d.delete();
    cyc0 = cyc;
  endtask

  // Issues n back-to-back requests from master m, holding stb while stalled.
  task automatic master_seq(input int m, input int n, input logic [31:0] addr,
                            input logic we, input logic [2:0] sel, input logic [31:0] wd,
                            input int budget, output int n_acc, output int first_acc);
    bit got;
    int w;
    n_acc     = 0;
    first_acc = -1;
    m_addr[m] = addr;
    m_we[m]   = we;
    m_sel[m]  = sel;
    m_wd[m]   = wd;
    m_stb[m]  = 1'b1;
    for (int k = 0; k < n; k++) begin
      got = 0;
      w   = 0;
      while (!got && w < budget) begin
        @(negedge clk);
        if (d_stall[m] === 1'b0) begin
          got = 1;
          if (first_acc < 0) first_acc = cyc - cyc0;
        end
        w++;
        tick();
      end
      if (!got) break;
      n_acc++;
      m_addr[m] = m_addr[m] + 32'd4;
    end
    m_stb[m] = 1'b0;
  endtask

  task automatic wait_acks(input int count, input int budget);
    int w = 0;
    while (ack_m.size() < count && w < budget) begin
      tick();
      w++;
    end
    chk("ack_count", ack_m.size(), count);
  endtask

  task automatic single(input int m, input logic [31:0] addr, input logic we,
                        input logic [2:0] sel, input logic [31:0] wd, output int acc_rel);
    int na;
    start_phase();
    master_seq(m, 1, addr, we, sel, wd, 20, na, acc_rel);
    chk("accepted", na, 1);
    wait_acks(1, 20);
  endtask

  initial begin
    int acc, na0, na1, a0, a1, m0_acks;
    rst_n   = 1'b0;
    s_stall = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_stb[m]  = 1'b1;
      m_addr[m] = (m == 0) ? 32'h10 : 32'h40;
      m_wd[m]   = 32'h0;
      m_we[m]   = 1'b0;
      m_sel[m]  = 3'b010;
    end

    // Reset held 2 cycles with both masters requesting.
    tick();
    tick();
    @(negedge clk);
    chk("rst_s_stb", s_stb, 0);
    chk("rst_m0_stall", d_stall[0], 1);
    chk("rst_m1_stall", d_stall[1], 1);
    chk("rst_busy", busy, 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_s_data", s_data, 0);
    chk("rst_s_we", s_we, 0);
    chk("rst_s_sel", s_sel, 0);
    chk("rst_m0_ack", d_ack[0], 0);
    chk("rst_m1_ack", d_ack[1], 0);
    chk("rst_m0_data", d_data[0], 0);
    chk("rst_m1_data", d_data[1], 0);
    tick();
    rst_n = 1'b1;
    start_phase();
    tick();
    @(negedge clk);
    chk("grant_after_release", s_stb, 1);
`ifdef WB_ARB_RR_EN
    chk("rel_m0_stall", d_stall[0], 0);
    chk("rel_m1_stall", d_stall[1], 1);
`else
    chk("rel_m0_stall", d_stall[0], 1);
    chk("rel_m1_stall", d_stall[1], 0);
`endif
    // Now in WAIT: reset and drop requests; the slave acks one cycle later.
    tick();
    m_stb[0] = 1'b0;
    m_stb[1] = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("late_ack_dropped", ack_m.size(), 0);

    // m0 word write then read back at 0x10.
    single(0, 32'h10, 1'b1, 3'b010, 32'hDEADBEEF, acc);
    chk("m0_wr_ack_cyc", ack_c[0] - cyc0, 3);
    single(0, 32'h10, 1'b0, 3'b010, 32'h0, acc);
    chk("m0_rd_acc_cyc", acc, 1);
    chk("m0_rd_ack_cyc", ack_c[0] - cyc0, 3);
    chk("m0_rd_ack_who", ack_m[0], 0);
    chk("m0_rd_data", ack_d[0], 32'hDEADBEEF);

    // m1 byte write then zero-extended byte read.
    single(1, 32'h21, 1'b1, 3'b000, 32'h000000A5, acc);
    chk("m1_wr_we", acc_we, 1);
    chk("m1_wr_addr", acc_addr, 32'h21);
    chk("m1_wr_sel", acc_sel, 3'b000);
    chk("m1_wr_ack_cyc", ack_c[0] - cyc0, 3);
    chk("m1_wr_ack_who", ack_m[0], 1);
    single(1, 32'h21, 1'b0, 3'b100, 32'h0, acc);
    chk("m1_rd_data", ack_d[0], 32'h000000A5);

    // Slave stalls for two ISSUE cycles.
    start_phase();
    s_stall = 1'b1;
    fork
      master_seq(0, 1, 32'h10, 1'b0, 3'b010, 32'h0, 20, na0, acc);
      begin
        repeat (3) tick();
        s_stall = 1'b0;
      end
    join
    wait_acks(1, 20);
    chk("stall_acc_cyc", acc, 3);
    chk("stall_ack_cyc", ack_c[0] - cyc0, 5);
    chk("stall_data", ack_d[0], 32'hDEADBEEF);

    // Fresh reset, then simultaneous single requests.
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    start_phase();
    fork
      master_seq(0, 1, 32'h10, 1'b0, 3'b010, 32'h0, 20, na0, a0);
      master_seq(1, 1, 32'h21, 1'b0, 3'b100, 32'h0, 20, na1, a1);
    join
    wait_acks(2, 20);
`ifdef WB_ARB_RR_EN
    chk("sim_first_who", ack_m[0], 0);
    chk("sim_second_who", ack_m[1], 1);
`else
    chk("sim_first_who", ack_m[0], 1);
    chk("sim_second_who", ack_m[1], 0);
`endif
    chk("sim_first_cyc", ack_c[0] - cyc0, 3);
    chk("sim_second_cyc", ack_c[1] - cyc0, 7);

    // Continuous traffic.
    start_phase();
`ifdef WB_ARB_RR_EN
    fork
      master_seq(0, 2, 32'h10, 1'b0, 3'b010, 32'h0, 20, na0, a0);
      master_seq(1, 2, 32'h20, 1'b0, 3'b010, 32'h0, 20, na1, a1);
    join
    wait_acks(4, 30);
    for (int i = 0; i < 4 && i < ack_m.size(); i++) begin
      chk($sformatf("rr_who_%0d", i), ack_m[i], i % 2);
      chk($sformatf("rr_cyc_%0d", i), ack_c[i] - cyc0, 3 + 4 * i);
    end
`else
    fork
      master_seq(1, 6, 32'h20, 1'b0, 3'b010, 32'h0, 20, na1, a1);
      master_seq(0, 1, 32'h10, 1'b0, 3'b010, 32'h0, 20, na0, a0);
    join
    wait_acks(6, 30);
    m0_acks = 0;
    foreach (ack_m[i]) if (ack_m[i] == 0) m0_acks++;
    chk("starve_m0_accepts", na0, 0);
    chk("starve_m0_acks", m0_acks, 0);
    chk("starve_m1_accepts", na1, 6);
`endif
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master to one-slave Wishbone arbiter placed in front of the unified memory.
- Shares the single memory port between the CPU instruction-fetch port (m0) and the load/store port (m1).
- Keeps exactly one transaction outstanding at the slave and routes the slave's ack and read data back to the master that issued it.
- Master and slave sides both use the memory's stb/stall/ack protocol, with the same data, addr, we and sel fields.

Parameters:
- AW, 32, address width.
- DW, 32, data width.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_reset_n  in  1  synchronous active-low reset.
- i_m0_stb, i_m1_stb  in  1  master request strobes.
- i_m0_addr, i_m1_addr  in  AW  master addresses.
- i_m0_data, i_m1_data  in  DW  master write data.
- i_m0_we, i_m1_we  in  1  master write enables.
- i_m0_sel, i_m1_sel  in  3  size code: 000 byte, 001 half, 010 word, 100 byte zero-extend, 101 half zero-extend.
- o_m0_stall, o_m1_stall  out  1  per-master stall.
- o_m0_ack, o_m1_ack  out  1  per-master ack.
- o_m0_data, o_m1_data  out  DW  per-master read data.
- o_s_stb  out  1  slave strobe.
- o_s_addr  out  AW  slave address.
- o_s_data  out  DW  slave write data.
- o_s_we  out  1  slave write enable.
- o_s_sel  out  3  slave size code.
- i_s_stall, i_s_ack  in  1  slave stall and ack.
- i_s_data  in  DW  slave read data.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: when i_reset_n=0 at an edge, state<=IDLE and grant<=none.
  - Round-robin pointer (when compiled in) <=m0.
  - Outputs after reset: o_s_stb=0, o_s_addr/o_s_data=0, o_s_we=0, o_s_sel=0, both o_mX_stall=1, both o_mX_ack=0, both o_mX_data=0, o_busy=0.
- States: IDLE, ISSUE, WAIT. State and grant are registered; outputs are decoded combinationally from state, grant and slave inputs.
- IDLE:
  - o_s_stb=0; both masters stalled.
  - If any i_mX_stb is high: select a winner, register the grant, go to ISSUE.
  - Default arbitration is fixed priority, m1 over m0.
- ISSUE:
  - o_s_stb=1; slave fields are muxed from the granted master.
  - Granted o_mX_stall = i_s_stall. The master sees acceptance in the same cycle the slave accepts.
  - If i_s_stall=0, go to WAIT; otherwise hold ISSUE.
  - Masters must hold stb and all request fields stable while stalled.
- WAIT:
  - o_s_stb=0.
  - On i_s_ack=1: granted o_mX_ack=1 and o_mX_data=i_s_data for that single cycle; go to IDLE.
- Non-granted master: always stall=1, ack=0, data=0.
- Latency with the memory slave (2 cycles after accept):
  - request seen in IDLE at cycle 0;
  - accept in ISSUE at cycle 1;
  - ack at cycle 3.
- One idle bubble follows every ack: back-to-back requests issue at most every 4 cycles.
- Simultaneous requests: one is granted; the loser stays stalled and is served on the next pass through IDLE.
- A master dropping stb during ISSUE is a protocol violation. The arbiter still completes the issued transaction.
- An i_s_ack received in IDLE or ISSUE is ignored and not forwarded. This covers a stray ack after reset mid-transaction.
- Reset during WAIT abandons the transaction; the late ack is dropped as above.
- The arbiter performs no address checks.

Optional Feature:
- Macro WB_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer names the preferred master.
  - On a grant, the pointer moves to the other master.
  - If only one master requests, it wins regardless of the pointer.
- Undefined: fixed priority m1 > m0 and no pointer register. m0 can starve under continuous m1 traffic.

Decomposition:
- Package wb_arb_pkg:
  - state encoding constants S_IDLE, S_ISSUE, S_WAIT;
  - grant codes GNT_NONE, GNT_M0, GNT_M1;
  - SEL_* size-code constants shared with the memory.
- Sub-module wb_arb_pick: combinational winner selection.
  - Inputs: two requests plus the pointer.
  - Outputs: winner code.
  - Contains the WB_ARB_RR_EN logic.

Test Plan:
- Reset: i_reset_n=0 for 2 cycles with both stb=1 -> o_s_stb=0, both stalls=1, o_busy=0. First grant appears 1 cycle after release.
- Single m0 read, addr=0x10, sel=010, memory word 0xDEADBEEF:
  - o_s_stb=1 at cycle 1, o_m0_stall=0 at cycle 1;
  - o_m0_ack=1 with o_m0_data=0xDEADBEEF at cycle 3;
  - o_m1_ack=0 throughout.
- m1 byte write, addr=0x21, data=0xA5, sel=000 -> slave sees we=1, addr=0x21, sel=000; o_m1_ack after 2 cycles. A follow-up m1 read of 0x21 with sel=100 returns 0x000000A5.
- Simultaneous m0 and m1 requests, macro undefined -> m1 served first and m0 served next. With continuous m1 requests, m0 is never acked within 20 cycles.
- Simultaneous continuous requests, WB_ARB_RR_EN defined -> grants alternate m0, m1, m0, m1 over 4 transactions, with acks spaced 4 cycles apart.
- Reset asserted in WAIT, slave acks 1 cycle later -> neither o_mX_ack asserts; the next m0 request completes normally.
